// File: rtl/pattern_serializer_if.sv
// Parallel-load / serial-out bus between a pattern source and pattern_serializer.
// master drives the pattern request; slave (the serializer) drives the serial line and status.
interface pattern_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic [LEN_W-1:0] len;
  logic             rpt;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output load, din, len, rpt,
    input  x, x_valid, busy, done, err
  );

  modport slave (
    input  load, din, len, rpt,
    output x, x_valid, busy, done, err
  );
endinterface

// File: rtl/pattern_serializer.sv
// Loads a parallel pattern and shifts it out MSB-first on x, one bit every DIV clocks,
// optionally repeating the word back-to-back while rpt is high at each word boundary.
module pattern_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned DIV   = 1
) (
  input logic                 clk,
  input logic                 init,
  pattern_serializer_if.slave bus
);

  localparam int unsigned      DivW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LEN_W-1:0] WidthL  = LEN_W'(WIDTH);
  localparam logic [DivW-1:0]  DivLast = DivW'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] save_q, save_d;
  logic [LEN_W-1:0] len_s_q, len_s_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
  logic [DivW-1:0]  divcnt_q, divcnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    save_d    = save_q;
    len_s_d   = len_s_q;
    bitcnt_d  = bitcnt_q;
    divcnt_d  = divcnt_q;
    x_d       = x_q;
    x_valid_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.load) begin
          if ((bus.len != '0) && (bus.len <= WidthL)) begin
            shreg_d  = bus.din;
            save_d   = bus.din;
            len_s_d  = bus.len;
            bitcnt_d = bus.len;
            divcnt_d = '0;
            busy_d   = 1'b1;
            state_d  = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StShift: begin
        divcnt_d = (divcnt_q == DivLast) ? '0 : divcnt_q + DivW'(1);
        if (divcnt_q == '0) begin
          if (bitcnt_q != '0) begin
            x_d       = shreg_q[WIDTH-1];
            x_valid_d = 1'b1;
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d  = bitcnt_q - LEN_W'(1);
          end else if (bus.rpt) begin
            // Word boundary in repeat mode: the reload edge already emits the first bit.
            x_d       = save_q[WIDTH-1];
            x_valid_d = 1'b1;
            shreg_d   = {save_q[WIDTH-2:0], 1'b0};
            bitcnt_d  = len_s_q - LEN_W'(1);
          end else begin
            x_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        x_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        x_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      save_q    <= '0;
      len_s_q   <= '0;
      bitcnt_q  <= '0;
      divcnt_q  <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      save_q    <= save_d;
      len_s_q   <= len_s_d;
      bitcnt_q  <= bitcnt_d;
      divcnt_q  <= divcnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
